// File: rtl/simon_pkg.sv
// Shared Simon 32/64 types, constants and round function for the cipher blocks.
package simon_pkg;

    localparam int WORD_W  = 16;
    localparam int BLOCK_W = 2 * WORD_W;
    localparam int ROUNDS  = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t x;
        word_t y;
    } block_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2)
    function automatic word_t simon_f(input word_t v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction

endpackage

// File: rtl/simon_decrypt_inv_round.sv
// One Simon inverse round: undoes an encryption round that used key k.
module simon_inv_round
    import simon_pkg::*;
(
    input  word_t x,
    input  word_t y,
    input  word_t k,
    output word_t x_new,
    output word_t y_new
);

    assign x_new = y;
    assign y_new = x ^ simon_f(y) ^ k;

endmodule

// File: rtl/simon_decrypt_iter.sv
// Iterative Simon 32/64 decryptor, round keys consumed from ROUNDS-1 down to 0.
// Define SIMON_DEC_UNROLL2_EN to apply two inverse rounds per clock.
module simon_decrypt_iter #(
    parameter int WORD_W = 16,
    parameter int ROUNDS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*WORD_W-1:0]      ciphertext,
    input  logic [ROUNDS*WORD_W-1:0] round_keys,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WORD_W-1:0]      plaintext,
    output logic                     busy
);
    import simon_pkg::*;

    localparam int RCNT_W = $clog2(ROUNDS);
`ifdef SIMON_DEC_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    // Round counter value on the final RUN edge.
    localparam int LAST = STEP - 1;

    if (WORD_W != simon_pkg::WORD_W) begin : g_bad_word
        $error("simon_decrypt_iter: WORD_W must match simon_pkg::WORD_W");
    end

    state_t            state_reg, state_next;
    block_t            blk_reg, blk_next;
    logic [RCNT_W-1:0] rcnt_reg, rcnt_next;
    block_t            round_out;
    word_t             keys [ROUNDS];

    for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_keys
        assign keys[gi] = round_keys[gi*WORD_W +: WORD_W];
    end

`ifdef SIMON_DEC_UNROLL2_EN
    if ((ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("simon_decrypt_iter: ROUNDS must be even when unrolled by two");
    end

    logic [RCNT_W-1:0] rcnt_lo;
    word_t             mid_x, mid_y;

    assign rcnt_lo = rcnt_reg - RCNT_W'(1);

    simon_inv_round u_round0 (
        .x     (blk_reg.x),
        .y     (blk_reg.y),
        .k     (keys[rcnt_reg]),
        .x_new (mid_x),
        .y_new (mid_y)
    );

    simon_inv_round u_round1 (
        .x     (mid_x),
        .y     (mid_y),
        .k     (keys[rcnt_lo]),
        .x_new (round_out.x),
        .y_new (round_out.y)
    );
`else
    simon_inv_round u_round0 (
        .x     (blk_reg.x),
        .y     (blk_reg.y),
        .k     (keys[rcnt_reg]),
        .x_new (round_out.x),
        .y_new (round_out.y)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            blk_reg   <= '0;
            rcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            blk_reg   <= blk_next;
            rcnt_reg  <= rcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        blk_next   = blk_reg;
        rcnt_next  = rcnt_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_next   = ciphertext;
                    rcnt_next  = RCNT_W'(ROUNDS - 1);
                    state_next = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                blk_next = round_out;
                if (rcnt_reg == RCNT_W'(LAST)) begin
                    state_next = DONE;
                end else begin
                    rcnt_next = rcnt_reg - RCNT_W'(STEP);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // A pending ciphertext is taken on the same edge as the result.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        blk_next   = ciphertext;
                        rcnt_next  = RCNT_W'(ROUNDS - 1);
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign plaintext = blk_reg;

endmodule

// File: tb/tb_simon_decrypt_iter.sv
// Directed and round-trip checks for the iterative Simon 32/64 decryptor.
module tb_simon_decrypt_iter;

    localparam int WORD_W = 16;
    localparam int ROUNDS = 32;
`ifdef SIMON_DEC_UNROLL2_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [31:0]              ciphertext = '0;
    logic [ROUNDS*WORD_W-1:0] round_keys = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [31:0]              plaintext;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    simon_decrypt_iter #(.WORD_W(WORD_W), .ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] bf(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    // Simon 32/64 key expansion (m = 4, sequence z0).
    function automatic logic [ROUNDS*WORD_W-1:0] key_sched(input logic [63:0] key);
        logic [15:0]              k [ROUNDS];
        logic [61:0]              z;
        logic [15:0]              tmp;
        logic [ROUNDS*WORD_W-1:0] r;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < ROUNDS; i++) begin
            tmp  = rotr(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ rotr(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        r = '0;
        for (int i = 0; i < ROUNDS; i++) r[i*WORD_W +: WORD_W] = k[i];
        return r;
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] pt, input logic [ROUNDS*WORD_W-1:0] rk);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ bf(x) ^ rk[i*WORD_W +: WORD_W];
            y = t;
        end
        return {x, y};
    endfunction

    // Offer ct and return just after the accepting edge.
    task automatic accept(input logic [31:0] ct);
        int guard = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        ciphertext = ct;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        ciphertext = $urandom;
    endtask

    // Count edges from the accepting edge until out_valid; ends at a negedge.
    task automatic wait_out(input bit junk, output int edges);
        edges = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid || edges > 100) break;
            check("run_busy", 32'(busy), 32'd1);
            if (junk) begin
                check("run_in_ready", 32'(in_ready), 32'd0);
                in_valid   = 1'($urandom_range(0, 1));
                ciphertext = $urandom;
            end
            @(posedge clk);
            edges++;
        end
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, plaintext, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic decrypt(input string tag, input logic [31:0] ct, input logic [31:0] exp, input bit junk);
        int edges;
        accept(ct);
        wait_out(junk, edges);
        check({tag, "_latency"}, 32'(edges), 32'(LAT));
        $display("txn %s: ct=%h pt=%h exp=%h edges=%0d", tag, ct, plaintext, exp, edges);
        take(tag, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [ROUNDS*WORD_W-1:0] kat_rk;
        logic [31:0]              p2, c2, pt, ct;
        int                       edges;

        kat_rk     = key_sched(KAT_KEY);
        round_keys = kat_rk;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plaintext", plaintext, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Known answer
        decrypt("kat", KAT_CT, KAT_PT, 1'b0);
        @(negedge clk);
        check("kat_idle_valid", 32'(out_valid), 32'd0);

        // Backpressure in DONE
        accept(KAT_CT);
        wait_out(1'b0, edges);
        check("bp_latency", 32'(edges), 32'(LAT));
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_plaintext", plaintext, KAT_PT);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_single_handshake", 32'(out_valid), 32'd0);
        check("bp_idle_busy", 32'(busy), 32'd0);
        $display("txn bp: pt=%h held 10 cycles", KAT_PT);

        // Back-to-back accept on the output handshake edge
        p2 = 32'h1234_5678;
        c2 = encrypt(p2, kat_rk);
        accept(KAT_CT);
        wait_out(1'b0, edges);
        check("b2b_first_plaintext", plaintext, KAT_PT);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ciphertext = c2;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_out(1'b0, edges);
        check("b2b_latency", 32'(edges), 32'(LAT));
        $display("txn b2b: ct=%h pt=%h exp=%h edges=%0d", c2, plaintext, p2, edges);
        take("b2b_second", p2);

        // Reset in the middle of RUN
        accept(KAT_CT);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_plaintext", plaintext, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        $display("txn mid_rst: in-flight block discarded");
        decrypt("after_rst", KAT_CT, KAT_PT, 1'b0);

        // Junk in_valid during RUN is ignored
        decrypt("junk", c2, p2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("junk_no_extra_valid", 32'(out_valid), 32'd0);
            check("junk_no_extra_busy", 32'(busy), 32'd0);
        end

        // Round trip with random keys and plaintexts
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            round_keys = key_sched({$urandom, $urandom});
            pt = $urandom;
            ct = encrypt(pt, round_keys);
            decrypt("rt", ct, pt, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
